// File: rtl/riscv_pkg.sv
// Shared widths, ALU codes and the ID/EX stage entry bundle.
// Imported by operand_fwd_mux and id_ex_operand_stage.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ALU_OP_W  = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1001;

  typedef struct packed {
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic                 use_imm;
    logic [ALU_OP_W-1:0]  alu_ctrl;
    logic [REG_IDX_W-1:0] rd_idx;
    logic                 reg_write;
  } stage_entry_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one operand: EX/MEM hit beats WB hit beats the base value.
// Register x0 always resolves to zero.
module operand_fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs_idx,
  input  logic [XLEN-1:0]      base,
  input  logic                 exm_wr_en,
  input  logic [REG_IDX_W-1:0] exm_rd_idx,
  input  logic [XLEN-1:0]      exm_data,
  input  logic                 wb_wr_en,
  input  logic [REG_IDX_W-1:0] wb_rd_idx,
  input  logic [XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]      value
);

  logic nz;
  logic exm_hit;
  logic wb_hit;

  assign nz      = (rs_idx != '0);
  assign exm_hit = exm_wr_en & (exm_rd_idx == rs_idx);
  assign wb_hit  = wb_wr_en & (wb_rd_idx == rs_idx);

  always_comb begin
    value = base;
    if (!nz)          value = '0;
    else if (exm_hit) value = exm_data;
    else if (wb_hit)  value = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: main+skid buffer in front of the ALU.
// FORWARD_PATH_EN selects forwarding/snooping; otherwise an interlock.
module id_ex_operand_stage
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_IDX_W-1:0] dec_rs1_idx,
  input  logic [REG_IDX_W-1:0] dec_rs2_idx,
  input  logic [REG_IDX_W-1:0] dec_rd_idx,
  input  logic [XLEN-1:0]      dec_rs1_data,
  input  logic [XLEN-1:0]      dec_rs2_data,
  input  logic [XLEN-1:0]      dec_imm,
  input  logic                 dec_use_imm,
  input  logic [ALU_OP_W-1:0]  dec_alu_ctrl,
  input  logic                 dec_reg_write,
  input  logic                 exm_wr_en,
  input  logic [REG_IDX_W-1:0] exm_rd_idx,
  input  logic [XLEN-1:0]      exm_data,
  input  logic                 wb_wr_en,
  input  logic [REG_IDX_W-1:0] wb_rd_idx,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_a,
  output logic [XLEN-1:0]      ex_b,
  output logic [ALU_OP_W-1:0]  ex_alu_ctrl,
  output logic [REG_IDX_W-1:0] ex_rd_idx,
  output logic                 ex_reg_write
);

  stage_entry_t main_q, skid_q;
  stage_entry_t new_e, main_snp, skid_snp;
  logic         main_v, skid_v;
  logic         hazard, accept, xfer;

  // slot 0 = decode, 1 = main, 2 = skid
  logic [REG_IDX_W-1:0] rs1_s [3];
  logic [REG_IDX_W-1:0] rs2_s [3];
  logic [XLEN-1:0]      a_s   [3];
  logic [XLEN-1:0]      b_s   [3];
  logic                 ui_s  [3];
  logic [XLEN-1:0]      a_r   [3];
  logic [XLEN-1:0]      b_r   [3];

  assign rs1_s[0] = dec_rs1_idx;
  assign rs2_s[0] = dec_rs2_idx;
  assign a_s[0]   = dec_rs1_data;
  assign b_s[0]   = dec_use_imm ? dec_imm : dec_rs2_data;
  assign ui_s[0]  = dec_use_imm;
  assign rs1_s[1] = main_q.rs1_idx;
  assign rs2_s[1] = main_q.rs2_idx;
  assign a_s[1]   = main_q.a;
  assign b_s[1]   = main_q.b;
  assign ui_s[1]  = main_q.use_imm;
  assign rs1_s[2] = skid_q.rs1_idx;
  assign rs2_s[2] = skid_q.rs2_idx;
  assign a_s[2]   = skid_q.a;
  assign b_s[2]   = skid_q.b;
  assign ui_s[2]  = skid_q.use_imm;

`ifdef FORWARD_PATH_EN
  logic [XLEN-1:0] a_f [3];
  logic [XLEN-1:0] b_f [3];

  for (genvar i = 0; i < 3; i++) begin : g_fwd
    operand_fwd_mux u_a (
      .rs_idx    (rs1_s[i]),
      .base      (a_s[i]),
      .exm_wr_en (exm_wr_en),
      .exm_rd_idx(exm_rd_idx),
      .exm_data  (exm_data),
      .wb_wr_en  (wb_wr_en),
      .wb_rd_idx (wb_rd_idx),
      .wb_data   (wb_data),
      .value     (a_f[i])
    );
    operand_fwd_mux u_b (
      .rs_idx    (rs2_s[i]),
      .base      (b_s[i]),
      .exm_wr_en (exm_wr_en),
      .exm_rd_idx(exm_rd_idx),
      .exm_data  (exm_data),
      .wb_wr_en  (wb_wr_en),
      .wb_rd_idx (wb_rd_idx),
      .wb_data   (wb_data),
      .value     (b_f[i])
    );
    assign a_r[i] = a_f[i];
    assign b_r[i] = ui_s[i] ? b_s[i] : b_f[i];
  end

  assign hazard = 1'b0;
`else
  logic rs1_nz, rs2_nz;
  logic unused_ok;

  assign rs1_nz = (dec_rs1_idx != '0);
  assign rs2_nz = (dec_rs2_idx != '0) & ~dec_use_imm;

  function automatic logic hit(
    input logic                 en,
    input logic [REG_IDX_W-1:0] rd
  );
    return en & ((rs1_nz & (rd == dec_rs1_idx)) |
                 (rs2_nz & (rd == dec_rs2_idx)));
  endfunction

  assign hazard = hit(main_v & main_q.reg_write, main_q.rd_idx)
                | hit(skid_v & skid_q.reg_write, skid_q.rd_idx)
                | hit(exm_wr_en, exm_rd_idx)
                | hit(wb_wr_en, wb_rd_idx);

  assign a_r[0] = rs1_nz ? dec_rs1_data : '0;
  assign b_r[0] = (dec_use_imm | rs2_nz) ? b_s[0] : '0;
  assign a_r[1] = a_s[1];
  assign b_r[1] = b_s[1];
  assign a_r[2] = a_s[2];
  assign b_r[2] = b_s[2];

  assign unused_ok = ^{exm_data, wb_data, ui_s[1], ui_s[2],
                       rs1_s[1], rs2_s[1], rs1_s[2], rs2_s[2]};
`endif

  always_comb begin
    new_e           = '0;
    new_e.a         = a_r[0];
    new_e.b         = b_r[0];
    new_e.rs1_idx   = dec_rs1_idx;
    new_e.rs2_idx   = dec_rs2_idx;
    new_e.use_imm   = dec_use_imm;
    new_e.alu_ctrl  = dec_alu_ctrl;
    new_e.rd_idx    = dec_rd_idx;
    new_e.reg_write = dec_reg_write;
    main_snp        = main_q;
    main_snp.a      = a_r[1];
    main_snp.b      = b_r[1];
    skid_snp        = skid_q;
    skid_snp.a      = a_r[2];
    skid_snp.b      = b_r[2];
  end

  assign dec_ready = ~skid_v & ~hazard;
  assign accept    = dec_valid & dec_ready;
  assign xfer      = main_v & ex_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || xfer) begin
      // main frees up: skid drains first, else take decode
      if (skid_v) begin
        main_q <= skid_snp;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_q <= new_e;
        main_v <= 1'b1;
      end else begin
        main_v <= 1'b0;
      end
    end else begin
      main_q <= main_snp;
      if (accept) begin
        skid_q <= new_e;
        skid_v <= 1'b1;
      end else begin
        skid_q <= skid_snp;
      end
    end
  end

  assign ex_valid     = main_v;
  assign ex_a         = main_q.a;
  assign ex_b         = main_q.b;
  assign ex_alu_ctrl  = main_q.alu_ctrl;
  assign ex_rd_idx    = main_q.rd_idx;
  assign ex_reg_write = main_q.reg_write;

endmodule
